// File: rtl/dc_dw_weight_updater.sv
`default_nettype none
// ============================================================================
//  Module      : dc_dw_weight_updater
//  Description : Consumer of the backprop_stack dc_dw interface. Walks every
//                row of every layer, fetches the gradient row and the matching
//                weight row, and writes back w - (dc_dw >>> lr_shift) with
//                signed saturation. Three cycles per row (REQ, CAPT, WRITE).
//  Revision    : 1.0 - initial release
// ============================================================================
module dc_dw_weight_updater #(
    parameter int MAX_LAYER_SIZE = 4,
    parameter int DATA_SIZE      = 16,
    parameter int SIZE           = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               num_layers,
    input  logic [3:0]                lr_shift,
    output logic                      cal_dc_dw,
    output logic [31:0]               dc_dw_layer,
    output logic [31:0]               dc_dw_row,
    input  logic [DATA_SIZE*SIZE-1:0] dc_dw_stream,
    output logic                      weight_rd_en,
    output logic                      weight_wr_en,
    output logic [31:0]               weight_layer,
    output logic [31:0]               weight_row,
    input  logic [DATA_SIZE*SIZE-1:0] weight_rd_data,
    output logic [DATA_SIZE*SIZE-1:0] weight_wr_data,
    output logic                      busy,
    output logic                      done
);

    localparam int ROW_W = DATA_SIZE * SIZE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_CAPT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_num_layers;
    logic [3:0]  r_lr_shift;
    logic [31:0] r_layer;
    logic [31:0] r_row;

    logic [31:0]      w_clamped;
    logic             w_row_wrap;
    logic             w_last;
    logic [31:0]      w_next_row;
    logic [31:0]      w_next_layer;
    logic [ROW_W-1:0] w_new_row;

    // Layer count is bounded by the number of layers the stack can hold.
    assign w_clamped = (num_layers > 32'(MAX_LAYER_SIZE)) ? 32'(MAX_LAYER_SIZE) : num_layers;

    // Row/layer walk: rows ascending inside a layer, layers ascending.
    assign w_row_wrap   = (r_row == 32'(SIZE - 1));
    assign w_last       = w_row_wrap && (r_layer == (r_num_layers - 32'd1));
    assign w_next_row   = w_row_wrap ? 32'd0 : (r_row + 32'd1);
    assign w_next_layer = w_row_wrap ? (r_layer + 32'd1) : r_layer;

    // Per-element update: element i sits in the MSB-first slot i of each row.
    for (genvar i = 0; i < SIZE; i++) begin : g_elem
        localparam logic [DATA_SIZE-1:0] c_sat_max = {1'b0, {(DATA_SIZE-1){1'b1}}};
        localparam logic [DATA_SIZE-1:0] c_sat_min = {1'b1, {(DATA_SIZE-1){1'b0}}};

        logic signed [DATA_SIZE-1:0] w_wt;
        logic signed [DATA_SIZE-1:0] w_grad;
        logic signed [DATA_SIZE-1:0] w_delta;
        logic signed [DATA_SIZE:0]   w_diff;
        logic        [DATA_SIZE-1:0] w_sat;

        assign w_wt    = weight_rd_data[(SIZE-i)*DATA_SIZE-1 -: DATA_SIZE];
        assign w_grad  = dc_dw_stream[(SIZE-i)*DATA_SIZE-1 -: DATA_SIZE];
        // Arithmetic shift rounds toward negative infinity.
        assign w_delta = w_grad >>> r_lr_shift;
        // One extra bit so the subtraction itself can never wrap.
        assign w_diff  = {w_wt[DATA_SIZE-1], w_wt} - {w_delta[DATA_SIZE-1], w_delta};
        // Top two bits disagree only when the result left the representable range.
        assign w_sat   = (w_diff[DATA_SIZE] != w_diff[DATA_SIZE-1])
                       ? (w_diff[DATA_SIZE] ? c_sat_min : c_sat_max)
                       : w_diff[DATA_SIZE-1:0];

        assign w_new_row[(SIZE-i)*DATA_SIZE-1 -: DATA_SIZE] = w_sat;
    end

    // Sequencer: every output is registered and strobes default low each cycle.
    // The update is computed straight off the returned buses during CAPT and
    // registered into weight_wr_data, so the write lands in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_num_layers   <= 32'd0;
            r_lr_shift     <= 4'd0;
            r_layer        <= 32'd0;
            r_row          <= 32'd0;
            cal_dc_dw      <= 1'b0;
            dc_dw_layer    <= 32'd0;
            dc_dw_row      <= 32'd0;
            weight_rd_en   <= 1'b0;
            weight_wr_en   <= 1'b0;
            weight_layer   <= 32'd0;
            weight_row     <= 32'd0;
            weight_wr_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            cal_dc_dw    <= 1'b0;
            weight_rd_en <= 1'b0;
            weight_wr_en <= 1'b0;
            done         <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_layers <= w_clamped;
                        r_lr_shift   <= lr_shift;
                        r_layer      <= 32'd0;
                        r_row        <= 32'd0;
                        if (w_clamped == 32'd0) begin
                            // Nothing to update: finish immediately without strobes.
                            done <= 1'b1;
                        end else begin
                            busy         <= 1'b1;
                            r_state      <= S_REQ;
                            cal_dc_dw    <= 1'b1;
                            weight_rd_en <= 1'b1;
                            dc_dw_layer  <= 32'd0;
                            dc_dw_row    <= 32'd0;
                            weight_layer <= 32'd0;
                            weight_row   <= 32'd0;
                        end
                    end
                end

                S_REQ: begin
                    r_state <= S_CAPT;
                end

                S_CAPT: begin
                    weight_wr_data <= w_new_row;
                    weight_wr_en   <= 1'b1;
                    r_state        <= S_WRITE;
                end

                S_WRITE: begin
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_row        <= w_next_row;
                        r_layer      <= w_next_layer;
                        cal_dc_dw    <= 1'b1;
                        weight_rd_en <= 1'b1;
                        dc_dw_layer  <= w_next_layer;
                        dc_dw_row    <= w_next_row;
                        weight_layer <= w_next_layer;
                        weight_row   <= w_next_row;
                        r_state      <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dc_dw_weight_updater.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dc_dw_weight_updater
//  Description : Directed self-checking bench for dc_dw_weight_updater with a
//                small weight/gradient memory responder and a write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_dw_weight_updater;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] num_layers;
    logic [3:0]  lr_shift;
    logic        cal_dc_dw;
    logic [31:0] dc_dw_layer;
    logic [31:0] dc_dw_row;
    logic [47:0] dc_dw_stream;
    logic        weight_rd_en;
    logic        weight_wr_en;
    logic [31:0] weight_layer;
    logic [31:0] weight_row;
    logic [47:0] weight_rd_data;
    logic [47:0] weight_wr_data;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    dc_dw_weight_updater #(
        .MAX_LAYER_SIZE(4),
        .DATA_SIZE     (16),
        .SIZE          (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_layers    (num_layers),
        .lr_shift      (lr_shift),
        .cal_dc_dw     (cal_dc_dw),
        .dc_dw_layer   (dc_dw_layer),
        .dc_dw_row     (dc_dw_row),
        .dc_dw_stream  (dc_dw_stream),
        .weight_rd_en  (weight_rd_en),
        .weight_wr_en  (weight_wr_en),
        .weight_layer  (weight_layer),
        .weight_row    (weight_row),
        .weight_rd_data(weight_rd_data),
        .weight_wr_data(weight_wr_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents served back to the DUT
    logic [47:0] wrow [0:3][0:2];
    logic [47:0] grow [0:3][0:2];

    // Observation logs
    logic [31:0] wr_l_q [$];
    logic [31:0] wr_r_q [$];
    logic [47:0] wr_d_q [$];
    logic [31:0] rq_l_q [$];
    logic [31:0] rq_r_q [$];
    int strobe_skew = 0;
    int done_count  = 0;
    int done_cyc    = 0;
    int start_cyc   = 0;
    bit busy_seen   = 0;

    function automatic logic [47:0] pack3(input int a, input int b, input int c);
        return {a[15:0], b[15:0], c[15:0]};
    endfunction

    // Monitor and memory responder, both away from the active edge
    always @(negedge clk) begin
        if (weight_wr_en) begin
            wr_l_q.push_back(weight_layer);
            wr_r_q.push_back(weight_row);
            wr_d_q.push_back(weight_wr_data);
        end
        if (cal_dc_dw || weight_rd_en) begin
            rq_l_q.push_back(dc_dw_layer);
            rq_r_q.push_back(dc_dw_row);
            if (cal_dc_dw !== weight_rd_en || dc_dw_layer !== weight_layer || dc_dw_row !== weight_row)
                strobe_skew++;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (busy) busy_seen = 1;
        if (weight_rd_en && weight_layer < 4 && weight_row < 3)
            weight_rd_data = wrow[weight_layer][weight_row];
        if (cal_dc_dw && dc_dw_layer < 4 && dc_dw_row < 3)
            dc_dw_stream = grow[dc_dw_layer][dc_dw_row];
    end

    task automatic clear_mem();
        for (int l = 0; l < 4; l++)
            for (int r = 0; r < 3; r++) begin
                wrow[l][r] = '0;
                grow[l][r] = '0;
            end
    endtask

    task automatic clear_logs();
        wr_l_q.delete(); wr_r_q.delete(); wr_d_q.delete();
        rq_l_q.delete(); rq_r_q.delete();
        strobe_skew = 0; done_count = 0; busy_seen = 0;
    endtask

    task automatic do_start(input int nl, input int sh);
        @(negedge clk);
        clear_logs();
        start = 1'b1; num_layers = nl; lr_shift = sh[3:0];
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_count == 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (done_count == 0) begin
            bad++;
            $display("FAIL %s_timeout: done not seen after %0d cycles, required within 300", name, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_layers = 0; lr_shift = 0;
        dc_dw_stream = '0; weight_rd_data = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({cal_dc_dw, weight_rd_en, weight_wr_en, busy, done} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b required 00000", {cal_dc_dw, weight_rd_en, weight_wr_en, busy, done});
        end
        total++;
        if ({dc_dw_layer, dc_dw_row, weight_layer, weight_row} !== 128'd0) begin
            bad++; $display("FAIL reset_idx: got %h required 0", {dc_dw_layer, dc_dw_row, weight_layer, weight_row});
        end
        total++;
        if (weight_wr_data !== 48'd0) begin
            bad++; $display("FAIL reset_wdata: got %h required 0", weight_wr_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [47:0] exp0;
        clear_mem();
        wrow[0][0] = pack3(100, -50, 0);
        grow[0][0] = pack3(10, -10, 5);
        exp0 = pack3(90, -40, -5);
        do_start(1, 0);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL basic_busy: got %b required 1", busy);
        end
        wait_done("basic");
        total++;
        if (wr_d_q.size() != 3) begin
            bad++; $display("FAIL basic_wcount: got %0d required 3", wr_d_q.size());
        end else begin
            total++;
            if (wr_d_q[0] !== exp0 || wr_l_q[0] !== 0 || wr_r_q[0] !== 0) begin
                bad++; $display("FAIL basic_row0: got %h @(%0d,%0d) required %h @(0,0)", wr_d_q[0], wr_l_q[0], wr_r_q[0], exp0);
            end
            total++;
            if (wr_d_q[1] !== 48'd0 || wr_r_q[1] !== 1 || wr_d_q[2] !== 48'd0 || wr_r_q[2] !== 2) begin
                bad++; $display("FAIL basic_rows12: got %h/%0d %h/%0d required 0/1 0/2", wr_d_q[1], wr_r_q[1], wr_d_q[2], wr_r_q[2]);
            end
        end
        total++;
        if (done_cyc - start_cyc != 10) begin
            bad++; $display("FAIL basic_latency: got %0d required 10", done_cyc - start_cyc);
        end
        total++;
        if (busy !== 1'b0 || done_count != 1) begin
            bad++; $display("FAIL basic_end: busy=%b dones=%0d required busy=0 dones=1", busy, done_count);
        end
    endtask

    task automatic test_saturation();
        logic [47:0] exp0;
        clear_mem();
        wrow[0][0] = pack3(-32760, 32767, 0);
        grow[0][0] = pack3(100, -5, 0);
        exp0 = pack3(-32768, 32767, 0);
        do_start(1, 0);
        wait_done("sat");
        total++;
        if (wr_d_q.size() < 1 || wr_d_q[0] !== exp0) begin
            bad++; $display("FAIL saturation: got %h required %h", (wr_d_q.size() > 0) ? wr_d_q[0] : 48'hx, exp0);
        end
    endtask

    task automatic test_shift();
        logic [47:0] exp0;
        clear_mem();
        grow[0][0] = pack3(-7, 7, 1);
        exp0 = pack3(4, -3, 0);
        do_start(1, 1);
        wait_done("shift");
        total++;
        if (wr_d_q.size() < 1 || wr_d_q[0] !== exp0) begin
            bad++; $display("FAIL shift: got %h required %h", (wr_d_q.size() > 0) ? wr_d_q[0] : 48'hx, exp0);
        end
    endtask

    task automatic test_order();
        clear_mem();
        do_start(2, 0);
        wait_done("order");
        total++;
        if (rq_l_q.size() != 6) begin
            bad++; $display("FAIL order_count: got %0d required 6", rq_l_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (rq_l_q[i] !== 32'(i / 3) || rq_r_q[i] !== 32'(i % 3)) begin
                    bad++; $display("FAIL order_req%0d: got (%0d,%0d) required (%0d,%0d)", i, rq_l_q[i], rq_r_q[i], i / 3, i % 3);
                end
            end
        end
        total++;
        if (strobe_skew != 0) begin
            bad++; $display("FAIL order_coincide: got %0d skewed requests required 0", strobe_skew);
        end
        do_start(9, 0);
        wait_done("clamp");
        total++;
        if (wr_l_q.size() != 12) begin
            bad++; $display("FAIL clamp_wcount: got %0d required 12", wr_l_q.size());
        end else begin
            total++;
            if (wr_l_q[11] !== 3 || wr_r_q[11] !== 2) begin
                bad++; $display("FAIL clamp_last: got (%0d,%0d) required (3,2)", wr_l_q[11], wr_r_q[11]);
            end
        end
    endtask

    task automatic test_zero();
        do_start(0, 0);
        wait_done("zero");
        total++;
        if (done_cyc - start_cyc != 1) begin
            bad++; $display("FAIL zero_latency: got %0d required 1", done_cyc - start_cyc);
        end
        total++;
        if (rq_l_q.size() != 0 || wr_l_q.size() != 0 || busy_seen) begin
            bad++; $display("FAIL zero_quiet: reqs=%0d writes=%0d busy_seen=%0d required 0 0 0", rq_l_q.size(), wr_l_q.size(), busy_seen);
        end
    endtask

    task automatic test_busy_start();
        clear_mem();
        grow[0][0] = pack3(8, 0, 0);
        do_start(1, 0);
        repeat (3) @(negedge clk);
        start = 1'b1; num_layers = 4; lr_shift = 4'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (15) @(negedge clk);
        total++;
        if (wr_l_q.size() != 3 || done_count != 1) begin
            bad++; $display("FAIL busy_start_count: writes=%0d dones=%0d required 3 1", wr_l_q.size(), done_count);
        end
        total++;
        if (wr_d_q.size() < 1 || wr_d_q[0] !== pack3(-8, 0, 0)) begin
            bad++; $display("FAIL busy_start_shift: got %h required %h", (wr_d_q.size() > 0) ? wr_d_q[0] : 48'hx, pack3(-8, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_mem();
        do_start(1, 0);
        n = 0;
        while (!(cal_dc_dw && dc_dw_row == 1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++; $display("FAIL rstmid_reach: request for row 1 not seen, required within 50 cycles");
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({cal_dc_dw, weight_rd_en, weight_wr_en, busy, done} !== 5'b0 ||
            {dc_dw_layer, dc_dw_row, weight_layer, weight_row} !== 128'd0 || weight_wr_data !== 48'd0) begin
            bad++; $display("FAIL rstmid_outputs: ctrl=%b row=%0d wdata=%h required all 0",
                            {cal_dc_dw, weight_rd_en, weight_wr_en, busy, done}, weight_row, weight_wr_data);
        end
        reset = 1'b0;
        repeat (15) @(negedge clk);
        total++;
        if (wr_l_q.size() != 1 || done_count != 0) begin
            bad++; $display("FAIL rstmid_abort: writes=%0d dones=%0d required 1 0", wr_l_q.size(), done_count);
        end
        do_start(1, 0);
        wait_done("rstmid_fresh");
        total++;
        if (wr_l_q.size() != 3) begin
            bad++; $display("FAIL rstmid_fresh: got %0d writes required 3", wr_l_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_shift();
        test_order();
        test_zero();
        test_busy_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
